// File: rtl/alu_bist_if.sv
// ALU operand/result bus between the BIST engine and the alu.
// Master drives operands and op; slave returns result and flags.
interface alu_bist_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       ALUControl;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;

  modport master (
    output a, b, ALUControl,
    input  Result, ALUFlags
  );

  modport slave (
    input  a, b, ALUControl,
    output Result, ALUFlags
  );
endinterface

// File: rtl/alu_bist.sv
// On-chip stimulus/response engine for the combinational alu.
// LFSR operands, all four ops per pair, NZCV model, first-fail capture.
module alu_bist #(
  parameter int          WIDTH     = 32,
  parameter int          N_VECTORS = 256,
  parameter logic [31:0] SEED      = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  alu_bist_if.master       alu,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [1:0]       fail_ctrl
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } state_e;

  localparam logic [31:0] SEED_C =
    (SEED == 32'd0) ? 32'd1 : SEED;
  localparam int CW =
    (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_VECTORS - 1);
  localparam int MSB = WIDTH - 1;

  state_e           state_q;
  logic [31:0]      lfsr_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       ctrl_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [15:0]      err_q;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;
  logic [1:0]       fail_ctrl_q;

  logic [31:0]      lfsr1_d;
  logic [31:0]      lfsr2_d;
  logic [WIDTH-1:0] bop_d;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] res_d;
  logic [3:0]       flags_d;
  logic             miss_d;
  logic             start_d;

  function automatic logic [31:0] step(
    input logic [31:0] l
  );
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // LFSR lookahead and the expected result/flags for the
  // operands and op currently on the bus.
  always_comb begin
    lfsr1_d = step(lfsr_q);
    lfsr2_d = step(lfsr1_d);
    bop_d   = ctrl_q[0] ? ~b_q : b_q;
    sum_d   = {1'b0, a_q} + {1'b0, bop_d}
            + {{WIDTH{1'b0}}, ctrl_q[0]};
    res_d   = sum_d[WIDTH-1:0];
    unique case (ctrl_q)
      2'b10:   res_d = a_q & b_q;
      2'b11:   res_d = a_q | b_q;
      default: res_d = sum_d[WIDTH-1:0];
    endcase
    flags_d[3] = res_d[MSB];
    flags_d[2] = (res_d == '0);
    flags_d[1] = sum_d[WIDTH] & ~ctrl_q[1];
    flags_d[0] = ~(a_q[MSB] ^ b_q[MSB] ^ ctrl_q[0])
               & (a_q[MSB] ^ sum_d[MSB]) & ~ctrl_q[1];
    miss_d  = (alu.Result != res_d)
            | (alu.ALUFlags != flags_d);
    start_d = start
            & ((state_q == IDLE) | (state_q == DONE));
  end

  // Run sequencer: load pair, check four ops, repeat, report.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_C;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_ctrl_q <= 2'b00;
    end else if (start_d) begin
      state_q     <= LOAD;
      lfsr_q      <= SEED_C;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_ctrl_q <= 2'b00;
    end else begin
      unique case (state_q)
        LOAD: begin
          a_q     <= lfsr_q[WIDTH-1:0];
          b_q     <= lfsr1_d[WIDTH-1:0];
          lfsr_q  <= lfsr2_d;
          ctrl_q  <= 2'b00;
          state_q <= CHECK;
        end
        CHECK: begin
          if (miss_d) begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            if (err_q == 16'd0) begin
              fail_a_q    <= a_q;
              fail_b_q    <= b_q;
              fail_ctrl_q <= ctrl_q;
            end
          end
          if (ctrl_q != 2'b11) begin
            ctrl_q <= ctrl_q + 2'b01;
          end else if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == 16'd0) & ~miss_d;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu.a          = a_q;
  assign alu.b          = b_q;
  assign alu.ALUControl = ctrl_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_a         = fail_a_q;
  assign fail_b         = fail_b_q;
  assign fail_ctrl      = fail_ctrl_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural alu with fault injection,
// reference operand sequence and expected-error prediction.
module tb_alu_bist;

  localparam int          W    = 32;
  localparam int          NV   = 4;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [W-1:0]  fail_a, fail_b;
  logic [1:0]    fail_ctrl;

  int tests = 0;
  int fails = 0;

  int           mode = 0;
  logic [31:0]  tgt_a;
  logic [1:0]   tgt_op;
  logic [35:0]  tgt_mask;

  logic [31:0]  va [NV];
  logic [31:0]  vb [NV];

  logic [31:0]  tr_a [$];
  logic [31:0]  tr_b [$];
  logic [1:0]   tr_c [$];

  alu_bist_if #(.WIDTH(W)) bus ();

  alu_bist #(
    .WIDTH(W), .N_VECTORS(NV), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .alu(bus.master),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count),
    .fail_a(fail_a), .fail_b(fail_b),
    .fail_ctrl(fail_ctrl)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lstep(input logic [31:0] l);
    logic [31:0] r;
    r = l / 2;
    if (l % 2 == 1) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // golden alu: {N,Z,C,V, Result}
  function automatic logic [35:0] ref_alu(
    input logic [1:0] op, input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      2'd1: begin
        r = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {r[31], r == 0, c, v, r};
  endfunction

  function automatic logic [35:0] inject(
    input int m, input logic [1:0] op,
    input logic [31:0] a, input logic [35:0] g
  );
    logic [35:0] f;
    f = g;
    if (m == 1 && op == 2'd3) f = g ^ 36'h1;
    if (m == 2 && op == 2'd1) f[33] = 1'b0;
    if (m == 3 && op == tgt_op && a == tgt_a) f = g ^ tgt_mask;
    return f;
  endfunction

  logic [35:0] alu_out;
  always_comb begin
    alu_out = inject(mode, bus.ALUControl, bus.a,
      ref_alu(bus.ALUControl, bus.a, bus.b));
    bus.Result   = alu_out[31:0];
    bus.ALUFlags = alu_out[35:32];
  end

  task automatic predict(
    input int m, output int e,
    output logic [31:0] fa, output logic [31:0] fb,
    output logic [1:0] fc
  );
    logic [35:0] g;
    e = 0; fa = 0; fb = 0; fc = 0;
    for (int i = 0; i < NV; i++) begin
      for (int op = 0; op < 4; op++) begin
        g = ref_alu(2'(op), va[i], vb[i]);
        if (inject(m, 2'(op), va[i], g) != g) begin
          if (e == 0) begin
            fa = va[i]; fb = vb[i]; fc = 2'(op);
          end
          e++;
        end
      end
    end
  endtask

  // pulse start (called just after a negedge), record bus
  // on every busy cycle until the run ends or the bound hits
  task automatic run_capture(
    output int n, output bit to,
    output logic [15:0] e0, output logic d0
  );
    tr_a.delete(); tr_b.delete(); tr_c.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = err_count;
    d0 = done;
    n = 0;
    while (busy && n < 500) begin
      tr_a.push_back(bus.a);
      tr_b.push_back(bus.b);
      tr_c.push_back(bus.ALUControl);
      n++;
      @(negedge clk);
    end
    to = (n >= 500);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, pass, err_count, fail_a, fail_b,
         fail_ctrl, bus.a, bus.b, bus.ALUControl} !== '0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b pass=%b err=%0d a=%h b=%h c=%b",
        busy, done, pass, err_count, bus.a, bus.b, bus.ALUControl);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_golden_run;
    int n; bit to; logic [15:0] e0; logic d0;
    mode = 0;
    run_capture(n, to, e0, d0);
    tests++;
    if (to || n != 5 * NV) begin
      fails++;
      $display("FAIL golden_busy_len: got %0d want %0d", n, 5 * NV);
    end
    tests++;
    if (!(done === 1 && pass === 1 && err_count === 0)) begin
      fails++;
      $display("FAIL golden_status: done=%b pass=%b err=%0d want 1 1 0",
        done, pass, err_count);
    end
    tests++;
    if (n > 1 && (tr_a[1] !== SEED || tr_b[1] !== lstep(SEED))) begin
      fails++;
      $display("FAIL golden_first_load: a=%h b=%h want %h %h",
        tr_a[1], tr_b[1], SEED, lstep(SEED));
    end
    for (int i = 0; i < n; i++) begin
      if (i % 5 != 0) begin
        tests++;
        if (tr_a[i] !== va[i / 5] || tr_b[i] !== vb[i / 5]
            || tr_c[i] !== 2'(i % 5 - 1)) begin
          fails++;
          $display("FAIL golden_trace[%0d]: a=%h b=%h c=%b want %h %h %b",
            i, tr_a[i], tr_b[i], tr_c[i], va[i / 5], vb[i / 5],
            2'(i % 5 - 1));
        end
      end
    end
  endtask

  task automatic test_fault(input int m, input string nm);
    int n; bit to; logic [15:0] e0; logic d0;
    int e; logic [31:0] fa, fb; logic [1:0] fc;
    mode = m;
    predict(m, e, fa, fb, fc);
    run_capture(n, to, e0, d0);
    tests++;
    if (to || done !== 1'b1) begin
      fails++;
      $display("FAIL %s_done: done=%b timeout=%0d", nm, done, to);
    end
    tests++;
    if (err_count !== 16'(e) || pass !== (e == 0)) begin
      fails++;
      $display("FAIL %s_err: err=%0d pass=%b want %0d %b",
        nm, err_count, pass, e, e == 0);
    end
    tests++;
    if (fail_a !== fa || fail_b !== fb || fail_ctrl !== fc) begin
      fails++;
      $display("FAIL %s_capture: a=%h b=%h c=%b want %h %h %b",
        nm, fail_a, fail_b, fail_ctrl, fa, fb, fc);
    end
    mode = 0;
  endtask

  task automatic test_start_held;
    int n;
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy && n < 500) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n != 5 * NV || done !== 1'b1) begin
      fails++;
      $display("FAIL held_run: busy_len=%0d done=%b want %0d 1",
        n, done, 5 * NV);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL held_restart: busy=%b done=%b want 1 0", busy, done);
    end
    start = 1'b0;
    n = 0;
    while (!done && n < 500) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL held_finish: done=%b want 1", done);
    end
  endtask

  task automatic test_reset_midrun;
    int n; bit to; logic [15:0] e0; logic d0;
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({busy, done, pass, err_count, fail_a, fail_b,
         fail_ctrl, bus.a, bus.b, bus.ALUControl} !== '0) begin
      fails++;
      $display("FAIL midrun_reset: busy=%b done=%b err=%0d a=%h c=%b want 0",
        busy, done, err_count, bus.a, bus.ALUControl);
    end
    @(negedge clk);
    reset = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL midrun_idle: busy=%b done=%b want 0 0", busy, done);
    end
    run_capture(n, to, e0, d0);
    tests++;
    if (to || n < 2 || tr_a[1] !== SEED || tr_b[1] !== vb[0]
        || pass !== 1'b1) begin
      fails++;
      $display("FAIL midrun_replay: a=%h b=%h pass=%b want %h %h 1",
        (n > 1) ? tr_a[1] : 32'h0, (n > 1) ? tr_b[1] : 32'h0,
        pass, SEED, vb[0]);
    end
  endtask

  task automatic test_back_to_back;
    int n1, n2; bit to1, to2; logic [15:0] e0; logic d0;
    logic [31:0] a1 [$];
    logic [31:0] b1 [$];
    mode = 1;
    run_capture(n1, to1, e0, d0);
    a1 = tr_a;
    b1 = tr_b;
    tests++;
    if (err_count !== 16'(NV)) begin
      fails++;
      $display("FAIL b2b_err1: err=%0d want %0d", err_count, NV);
    end
    run_capture(n2, to2, e0, d0);
    tests++;
    if (e0 !== 16'd0 || d0 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_clear: err=%0d done=%b want 0 0", e0, d0);
    end
    tests++;
    if (to1 || to2 || n1 != n2) begin
      fails++;
      $display("FAIL b2b_len: %0d vs %0d", n1, n2);
    end
    for (int i = 1; i < n1 && i < n2; i++) begin
      tests++;
      if (tr_a[i] !== a1[i] || tr_b[i] !== b1[i]
          || (i % 5 != 0 && tr_a[i] !== va[i / 5])) begin
        fails++;
        $display("FAIL b2b_trace[%0d]: a=%h/%h b=%h/%h",
          i, a1[i], tr_a[i], b1[i], tr_b[i]);
      end
    end
    mode = 0;
  endtask

  task automatic test_random_faults;
    int v;
    for (int k = 0; k < 8; k++) begin
      v        = $urandom_range(0, NV - 1);
      tgt_a    = va[v];
      tgt_op   = 2'($urandom_range(0, 3));
      tgt_mask = {4'($urandom), 32'($urandom)};
      if (tgt_mask == 36'h0) tgt_mask = 36'h1 << $urandom_range(0, 35);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      test_fault(3, "rand");
    end
  endtask

  initial begin
    logic [31:0] l;
    l = SEED;
    for (int i = 0; i < NV; i++) begin
      va[i] = l;
      vb[i] = lstep(l);
      l = lstep(lstep(l));
    end
    tgt_a = 0; tgt_op = 0; tgt_mask = 0;
    @(negedge clk);
    test_reset();
    test_golden_run();
    test_fault(1, "or_bit0");
    test_fault(2, "sub_carry");
    test_start_held();
    test_reset_midrun();
    test_back_to_back();
    test_random_faults();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
